adc_sample_capture: RTL and testbench



---
 rtl/adc_sample_capture.sv | 143 ++++++++++++++
 tb/tb_adc_sample_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_capture.sv
// Serial capture front-end for an 18-bit SAR ADC: conversion strobe, SCK/SDO readout, result latch.
// Define ADC_SAMPLE_OFFSET_BINARY_EN when the ADC outputs offset-binary (MSB is inverted on capture).
module adc_sample_capture #(
  parameter int unsigned WID       = 18,
  parameter int unsigned CONV_WAIT = 40,
  parameter int unsigned SCK_HALF  = 2
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           arm,
  output logic           conv,
  output logic           sck,
  input  logic           sdo,
  output logic [WID-1:0] data,
  output logic           finished
);

  localparam int unsigned WaitW = $clog2(CONV_WAIT + 1);
  localparam int unsigned HalfW = $clog2(SCK_HALF + 1);
  localparam int unsigned BitW  = $clog2(WID + 1);

  localparam logic [WaitW-1:0] WaitLoad = WaitW'(CONV_WAIT - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(SCK_HALF - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WID - 1);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StShift,
    StLatch,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [HalfW-1:0] half_q, half_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WID-1:0]   shreg_q, shreg_d;
  logic [WID-1:0]   data_q, data_d;
  logic             conv_q, conv_d;
  logic             sck_q, sck_d;
  logic             finished_q, finished_d;
  logic [WID-1:0]   sample;

`ifdef ADC_SAMPLE_OFFSET_BINARY_EN
  assign sample = shreg_q ^ {1'b1, {(WID - 1){1'b0}}};
`else
  assign sample = shreg_q;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    half_d     = half_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    conv_d     = conv_q;
    sck_d      = sck_q;
    finished_d = finished_q;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StConvert;
          conv_d  = 1'b1;
          wait_d  = WaitLoad;
        end
      end
      StConvert: begin
        if (wait_q == '0) begin
          state_d = StShift;
          conv_d  = 1'b0;
          sck_d   = 1'b0;
          half_d  = '0;
          bit_d   = '0;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StShift: begin
        if (half_q == HalfLast) begin
          half_d = '0;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            // Sample on the edge that raises sck.
            shreg_d = {shreg_q[WID-2:0], sdo};
          end else begin
            bit_d = bit_q + BitW'(1);
            if (bit_q == BitLast) begin
              sck_d   = 1'b0;
              state_d = StLatch;
            end
          end
        end else begin
          half_d = half_q + HalfW'(1);
        end
      end
      StLatch: begin
        data_d     = sample;
        finished_d = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        if (!arm) begin
          finished_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      half_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      conv_q     <= 1'b0;
      sck_q      <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      conv_q     <= conv_d;
      sck_q      <= sck_d;
      finished_q <= finished_d;
    end
  end

  assign conv     = conv_q;
  assign sck      = sck_q;
  assign data     = data_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboard bench for adc_sample_capture: drives an ADC model on SDO, checks latency and data.
module tb_adc_sample_capture;

  localparam int unsigned WID       = 18;
  localparam int unsigned CONV_WAIT = 4;
  localparam int unsigned SCK_HALF  = 1;
  localparam int unsigned LATENCY   = 1 + CONV_WAIT + 2 * SCK_HALF * WID;

  logic           clk;
  logic           rst_L;
  logic           arm;
  logic           conv;
  logic           sck;
  logic           sdo;
  logic [WID-1:0] data;
  logic           finished;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [WID-1:0] exp_q[$];
  logic [WID-1:0] cur_word;
  int unsigned    rise_cnt;
  int unsigned    conv_cnt;
  int unsigned    rise_base;
  int unsigned    conv_base;
  logic           sck_prev;

  adc_sample_capture #(
    .WID      (WID),
    .CONV_WAIT(CONV_WAIT),
    .SCK_HALF (SCK_HALF)
  ) u_dut (
    .clk     (clk),
    .rst_L   (rst_L),
    .arm     (arm),
    .conv    (conv),
    .sck     (sck),
    .sdo     (sdo),
    .data    (data),
    .finished(finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: presents the next MSB-first bit after each observed sck rise.
  initial begin
    rise_cnt = 0;
    conv_cnt = 0;
    sck_prev = 1'b0;
    sdo      = 1'b0;
    forever begin
      @(negedge clk);
      if (sck && !sck_prev) rise_cnt++;
      if (conv) conv_cnt++;
      sck_prev = sck;
      if ((rise_cnt - rise_base) < WID) sdo = cur_word[WID-1-(rise_cnt-rise_base)];
      else sdo = 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WID-1:0] model(input logic [WID-1:0] w);
`ifdef ADC_SAMPLE_OFFSET_BINARY_EN
    model = {~w[WID-1], w[WID-2:0]};
`else
    model = w;
`endif
  endfunction

  // Runs one capture. drop_early releases arm during CONVERT; otherwise arm is held 100 cycles.
  task automatic capture(input logic [WID-1:0] word, input bit drop_early);
    int unsigned n;
    int unsigned bad;
    logic [WID-1:0] exp;
    @(negedge clk);
    cur_word  = word;
    rise_base = rise_cnt;
    conv_base = conv_cnt;
    exp_q.push_back(model(word));
    arm = 1'b1;
    @(posedge clk);
    #1;
    check_val("conv_after_arm", 32'(conv), 32'd1);
    n = 0;
    while (!finished && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (drop_early && n == 2) arm = 1'b0;
    end
    check_val("finish_latency", n, LATENCY);
    check_val("sck_rises", rise_cnt - rise_base, WID);
    check_val("conv_cycles", conv_cnt - conv_base, CONV_WAIT);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_val("data", 32'(data), 32'(exp));
    end else begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end
    if (drop_early) begin
      @(posedge clk);
      #1;
      check_val("finished_pulse", 32'(finished), 32'd0);
    end else begin
      bad = 0;
      repeat (100) begin
        @(posedge clk);
        #1;
        if (!finished || conv) bad++;
      end
      check_val("hold_done", bad, 0);
      arm = 1'b0;
      @(posedge clk);
      #1;
      check_val("finished_release", 32'(finished), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("data_hold_idle", 32'(data), 32'(model(word)));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rise_base = 0;
    conv_base = 0;
    cur_word  = '0;
    arm       = 1'b0;
    rst_L     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_conv", 32'(conv), 32'd0);
    check_val("rst_sck", 32'(sck), 32'd0);
    check_val("rst_finished", 32'(finished), 32'd0);
    check_val("rst_data", 32'(data), 32'd0);
    rst_L = 1'b1;

    capture(18'h2AAAA, 1'b0);
    capture(18'h3FFFF, 1'b0);
    capture(18'h00000, 1'b1);
    capture(WID'($urandom), 1'b0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    cur_word  = 18'h15555;
    rise_base = rise_cnt;
    arm       = 1'b1;
    repeat (CONV_WAIT + 6) @(posedge clk);
    #1;
    rst_L = 1'b0;
    #1;
    check_val("midrst_conv", 32'(conv), 32'd0);
    check_val("midrst_sck", 32'(sck), 32'd0);
    check_val("midrst_finished", 32'(finished), 32'd0);
    check_val("midrst_data", 32'(data), 32'd0);
    arm = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    capture(18'h1C3A5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
